// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one FPU core between NUM_REQ requesters.
// Latches the winner's operands, runs the core under a watchdog, returns the result via start/done.
module fpu_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic [NUM_REQ-1:0]        req_start,
  input  logic [4*NUM_REQ-1:0]      req_op,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      req_err,
  output logic [DATA_W-1:0]         req_result,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic                      core_start,
  output logic [3:0]                core_op,
  output logic [DATA_W-1:0]         core_a,
  output logic [DATA_W-1:0]         core_b,
  output logic                      core_abort,
  input  logic                      core_done,
  input  logic [DATA_W-1:0]         core_result
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] OpIllegal = 4'hF;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StIssue   = 3'd1;
  localparam logic [2:0] StWait    = 3'd2;
  localparam logic [2:0] StFinish  = 3'd3;
  localparam logic [2:0] StWaitAck = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [3:0]         op_q, op_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]  res_q, res_d, out_res_q, out_res_d;
  logic               err_q, err_d, out_err_q, out_err_d;

  logic               win_found;
  logic [PtrW-1:0]    win_idx, scan_idx;
  logic [3:0]         win_op;
  logic [DATA_W-1:0]  win_a, win_b;
  logic               owner_released;

  // First requesting index at or after ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = PtrW'((32'(ptr_q) + k) % NUM_REQ);
      if (!win_found && req_start[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    win_op = '0;
    win_a  = '0;
    win_b  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PtrW'(i)) begin
        win_op = req_op[4*i +: 4];
        win_a  = req_a[DATA_W*i +: DATA_W];
        win_b  = req_b[DATA_W*i +: DATA_W];
      end
    end
  end

  assign owner_released = ~|(req_start & grant_q);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    done_d    = done_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    err_d     = err_q;
    out_res_d = out_res_q;
    out_err_d = out_err_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          op_d             = win_op;
          a_d              = win_a;
          b_d              = win_b;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          ptr_d            = (win_idx == PtrW'(NUM_REQ - 1)) ? '0 : win_idx + PtrW'(1);
          if (win_op == OpIllegal) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = StFinish;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        // A done arriving on the last counted cycle still wins over the abort.
        if (core_done) begin
          res_d   = core_result;
          err_d   = 1'b0;
          state_d = StFinish;
        end else if (cnt_q == CntLast) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = StFinish;
        end
      end
      StFinish: begin
        out_res_d = res_q;
        out_err_d = err_q;
        done_d    = grant_q;
        state_d   = StWaitAck;
      end
      StWaitAck: begin
        if (owner_released) begin
          done_d    = '0;
          grant_d   = '0;
          out_err_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
      out_res_q <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      err_q     <= err_d;
      out_res_q <= out_res_d;
      out_err_q <= out_err_d;
    end
  end

  assign req_done   = done_q;
  assign req_err    = out_err_q;
  assign req_result = out_res_q;
  assign req_grant  = grant_q;
  assign core_start = (state_q == StIssue);
  assign core_op    = op_q;
  assign core_a     = a_q;
  assign core_b     = b_q;
  assign core_abort = (state_q == StWait) && (cnt_q == CntLast) && !core_done;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: behavioural core model plus a transaction-level round-robin scoreboard.
module tb_fpu_arbiter;
  localparam int unsigned N = 2;
  localparam int unsigned W = 32;
  localparam int unsigned T = 16;

  logic           clk = 1'b0;
  logic           arst_n;
  logic [N-1:0]   req_start;
  logic [4*N-1:0] req_op;
  logic [W*N-1:0] req_a, req_b;
  logic [N-1:0]   req_done, req_grant;
  logic           req_err;
  logic [W-1:0]   req_result;
  logic           core_start, core_abort, core_done;
  logic [3:0]     core_op;
  logic [W-1:0]   core_a, core_b, core_result;

  fpu_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .arst_n(arst_n),
    .req_start(req_start), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_done(req_done), .req_err(req_err), .req_result(req_result), .req_grant(req_grant),
    .core_start(core_start), .core_op(core_op), .core_a(core_a), .core_b(core_b),
    .core_abort(core_abort), .core_done(core_done), .core_result(core_result)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Core model: responds cm_lat cycles after core_start; a reset or abort cancels it.
  int         cm_force_lat = 0;
  bit         cm_keep_late = 1'b0;
  int         start_cnt = 0, start_cyc = 0, cm_lat = 0;
  int         abort_cnt = 0, abort_cyc = 0;
  logic [3:0] cm_op = '0;
  logic [W-1:0] cm_a = '0, cm_b = '0;

  function automatic logic [W-1:0] core_fn(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    return (a ^ {b[W-5:0], op}) + b;
  endfunction

  initial begin : core_model
    int rem, elapsed, lat;
    bit pend;
    rem = 0; elapsed = 0; lat = 0; pend = 1'b0;
    core_done = 1'b0;
    core_result = '0;
    forever begin
      @(posedge clk); #1;
      core_done = 1'b0;
      if (!arst_n) begin
        pend = 1'b0;
      end else if (core_start) begin
        if (cm_force_lat > 0) lat = cm_force_lat;
        else begin
          case ($urandom_range(0, 9))
            0:       lat = int'(T);
            1:       lat = 3 * int'(T);
            default: lat = int'($urandom_range(1, 10));
          endcase
        end
        pend = 1'b1; rem = lat; elapsed = 0;
        start_cnt++; start_cyc = cyc; cm_lat = lat;
        cm_op = core_op; cm_a = core_a; cm_b = core_b;
      end else if (pend) begin
        rem--; elapsed++;
        if (rem == 0) begin
          core_done = 1'b1;
          core_result = core_fn(cm_op, cm_a, cm_b);
          pend = 1'b0;
        end else if (elapsed >= int'(T) && !cm_keep_late) begin
          pend = 1'b0;
        end
      end
    end
  end

  initial begin : abort_monitor
    forever begin
      @(negedge clk);
      if (core_abort) begin
        abort_cnt++;
        abort_cyc = cyc;
      end
    end
  end

  // Reference model: rotating priority pointer and per-requester transaction record.
  int           m_ptr = 0;
  logic [3:0]   r_op [N];
  logic [W-1:0] r_a  [N];
  logic [W-1:0] r_b  [N];

  function automatic int pick(input logic [N-1:0] pend);
    for (int k = 0; k < int'(N); k++) begin
      int i;
      i = (m_ptr + k) % int'(N);
      if (pend[i]) return i;
    end
    return 0;
  endfunction

  task automatic raise(input logic [N-1:0] mask, input int force_op);
    for (int i = 0; i < int'(N); i++) begin
      if (mask[i]) begin
        if (force_op >= 0) r_op[i] = 4'(force_op);
        else r_op[i] = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        r_a[i] = $urandom;
        r_b[i] = $urandom;
        req_op[4*i +: 4] = r_op[i];
        req_a[W*i +: W]  = r_a[i];
        req_b[W*i +: W]  = r_b[i];
      end
    end
    req_start = req_start | mask;
  endtask

  task automatic wait_done(output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (req_done != '0) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done"}, 64'(req_done), 64'd0);
    check({tag, "_grant"}, 64'(req_grant), 64'd0);
    check({tag, "_err"}, 64'(req_err), 64'd0);
    check({tag, "_result"}, 64'(req_result), 64'd0);
    check({tag, "_start_abort"}, 64'({core_start, core_abort}), 64'd0);
    check({tag, "_core_bus"}, 64'({core_op, core_a ^ core_b, core_a}), 64'd0);
  endtask

  // Serve every pending requester in model order, checking each completion and release.
  task automatic serve(input logic [N-1:0] pend_in, input int raise_cyc, input bit chk_lat,
                       input int hold);
    logic [N-1:0] pend;
    logic [W-1:0] exp_res;
    bit first, ok, is_ill, is_to, exp_err;
    int exp_i, t, s0, a0, h, exp_lat;
    pend  = pend_in;
    first = 1'b1;
    while (pend != '0) begin
      exp_i = pick(pend);
      m_ptr = (exp_i + 1) % int'(N);
      s0 = start_cnt;
      a0 = abort_cnt;
      wait_done(t, ok);
      check("done_seen", 64'(ok), 64'd1);
      if (!ok) begin
        req_start = '0;
        return;
      end
      is_ill  = (r_op[exp_i] == 4'hF);
      is_to   = !is_ill && (cm_lat > int'(T));
      exp_err = is_ill || is_to;
      exp_res = exp_err ? '0 : core_fn(r_op[exp_i], r_a[exp_i], r_b[exp_i]);
      check("grant", 64'(req_grant), 64'(1) << exp_i);
      check("done", 64'(req_done), 64'(1) << exp_i);
      check("err", 64'(req_err), 64'(exp_err));
      check("result", 64'(req_result), 64'(exp_res));
      check("core_starts", 64'(start_cnt - s0), is_ill ? 64'd0 : 64'd1);
      check("core_aborts", 64'(abort_cnt - a0), is_to ? 64'd1 : 64'd0);
      if (is_ill) begin
        check("core_op_ill", 64'(core_op), 64'hF);
      end else begin
        check("core_operands", {28'(cm_op), cm_a ^ cm_b}, {28'(r_op[exp_i]), r_a[exp_i] ^ r_b[exp_i]});
        check("core_a", 64'(cm_a), 64'(r_a[exp_i]));
      end
      if (is_to) check("abort_lat", 64'(abort_cyc - start_cyc), 64'(T));
      if (chk_lat && first) begin
        exp_lat = is_ill ? 2 : ((is_to ? int'(T) : cm_lat) + 3);
        check("latency", 64'(t - raise_cyc), 64'(exp_lat));
      end
      h = (hold < 0) ? int'($urandom_range(0, 2)) : hold;
      repeat (h) begin
        @(posedge clk); #1;
        check("done_hold", 64'({req_done, req_err}), {(64'(1) << exp_i), 1'b0} | 64'(exp_err));
        check("res_hold", 64'(req_result), 64'(exp_res));
      end
      req_start[exp_i] = 1'b0;
      @(posedge clk); #1;
      check("release", 64'({req_done, req_grant, req_err}), 64'd0);
      pend[exp_i] = 1'b0;
      first = 1'b0;
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t0, a0;
    logic [N-1:0] mask;
    arst_n    = 1'b0;
    req_start = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk); #1;

    // Single requester, fixed operands and 5-cycle core.
    cm_force_lat = 5;
    r_op[0] = 4'h0; r_a[0] = 32'h3F80_0000; r_b[0] = 32'h4000_0000;
    req_op[3:0] = r_op[0]; req_a[W-1:0] = r_a[0]; req_b[W-1:0] = r_b[0];
    req_start[0] = 1'b1;
    t0 = cyc;
    serve(2'b01, t0, 1'b1, 1);

    // Simultaneous pairs must alternate.
    cm_force_lat = 0;
    repeat (4) begin
      raise(2'b11, 0);
      t0 = cyc;
      serve(2'b11, t0, 1'b1, -1);
    end

    // Illegal opcode never reaches the core.
    raise(2'b10, 15);
    t0 = cyc;
    serve(2'b10, t0, 1'b1, -1);

    // Timeout with a late core_done while the result is held.
    cm_force_lat = 20;
    cm_keep_late = 1'b1;
    raise(2'b01, 3);
    t0 = cyc;
    serve(2'b01, t0, 1'b1, 5);
    cm_keep_late = 1'b0;

    // core_done on the last counted cycle.
    cm_force_lat = int'(T);
    raise(2'b10, 2);
    t0 = cyc;
    serve(2'b10, t0, 1'b1, -1);

    // Reset while waiting on the core; ptr must restart at 0.
    cm_force_lat = 3 * int'(T);
    raise(2'b01, 1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("pre_reset_grant", 64'(req_grant), 64'd1);
    raise(2'b10, 4);
    a0 = abort_cnt;
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    check_all_zero("reset_async");
    @(negedge clk);
    arst_n = 1'b1;
    m_ptr = 0;
    cm_force_lat = 5;
    serve(2'b11, 0, 1'b0, -1);
    check("reset_no_abort", 64'(abort_cnt - a0), 64'd0);

    // Randomized traffic.
    cm_force_lat = 0;
    repeat (40) begin
      mask = N'($urandom_range(1, 3));
      raise(mask, -1);
      t0 = cyc;
      serve(mask, t0, 1'b1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
